// File: rtl/osc_clk_enable_gen_pkg.sv
// Shared MSX timing constants and the phase-increment helper for the oscillator enable generator.
package osc_clk_enable_gen_pkg;

  localparam int MSX_LINE_LEN   = 228;
  localparam int MSX_LINES_NTSC = 262;

  localparam longint unsigned OSC_FREQ_HZ = 64'd17857143;
  localparam longint unsigned CPU_FREQ_HZ = 64'd3579545;

  // Truncating division keeps f_cpu at or just below nominal; yields 3363068 for a 24-bit accumulator.
  function automatic int unsigned calc_inc(input int unsigned acc_width);
    longint unsigned num;
    num = CPU_FREQ_HZ << acc_width;
    return 32'(num / OSC_FREQ_HZ);
  endfunction

endpackage

// File: rtl/msx_raster_counter.sv
// CPU-cycle / scanline position counter; wrap flags describe the current position so the
// caller can qualify them with its own enable.
module msx_raster_counter
  import osc_clk_enable_gen_pkg::*;
#(
  parameter int LINE_LEN        = MSX_LINE_LEN,
  parameter int LINES_PER_FRAME = MSX_LINES_NTSC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [7:0] line_cyc_o,
  output logic [8:0] line_num_o,
  output logic       line_wrap_o,
  output logic       frame_wrap_o
);

  localparam logic [7:0] CYC_LAST = 8'(LINE_LEN - 1);
  localparam logic [8:0] NUM_LAST = 9'(LINES_PER_FRAME - 1);

  logic [7:0] cyc_q, cyc_d;
  logic [8:0] num_q, num_d;

  assign line_wrap_o  = (cyc_q == CYC_LAST);
  assign frame_wrap_o = line_wrap_o && (num_q == NUM_LAST);

  always_comb begin
    cyc_d = cyc_q;
    num_d = num_q;
    if (clr_i) begin
      cyc_d = '0;
      num_d = '0;
    end else if (en_i) begin
      if (line_wrap_o) begin
        cyc_d = '0;
        num_d = frame_wrap_o ? '0 : num_q + 9'd1;
      end else begin
        cyc_d = cyc_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '0;
      num_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      num_q <= num_d;
    end
  end

  assign line_cyc_o = cyc_q;
  assign line_num_o = num_q;

endmodule

// File: rtl/osc_clk_enable_gen.sv
// Phase-accumulator CPU clock-enable with PSG, scanline and frame enables derived from it,
// all as one-clk pulses on the oscillator domain.
module osc_clk_enable_gen
  import osc_clk_enable_gen_pkg::*;
#(
  parameter int          ACC_WIDTH       = 24,
  parameter int unsigned INC             = 3363068,
  parameter int          LINE_LEN        = MSX_LINE_LEN,
  parameter int          LINES_PER_FRAME = MSX_LINES_NTSC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       resync,
  output logic       ce_cpu,
  output logic       ce_psg,
  output logic       ce_line,
  output logic       ce_frame,
  output logic [7:0] line_cyc,
  output logic [8:0] line_num
);

  localparam logic [ACC_WIDTH:0] INC_W = (ACC_WIDTH + 1)'(INC);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 carry;
  logic                 tick;
  logic                 psg_q;
  logic                 ce_cpu_q, ce_psg_q, ce_line_q, ce_frame_q;
  logic                 line_wrap, frame_wrap;

  assign {carry, acc_d} = {1'b0, acc_q} + INC_W;
  assign tick = carry & run & ~resync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      psg_q      <= 1'b0;
      ce_cpu_q   <= 1'b0;
      ce_psg_q   <= 1'b0;
      ce_line_q  <= 1'b0;
      ce_frame_q <= 1'b0;
    end else if (resync) begin
      acc_q      <= '0;
      psg_q      <= 1'b0;
      ce_cpu_q   <= 1'b0;
      ce_psg_q   <= 1'b0;
      ce_line_q  <= 1'b0;
      ce_frame_q <= 1'b0;
    end else if (run) begin
      acc_q      <= acc_d;
      psg_q      <= psg_q ^ carry;
      ce_cpu_q   <= carry;
      ce_psg_q   <= carry & psg_q;
      ce_line_q  <= carry & line_wrap;
      ce_frame_q <= carry & frame_wrap;
    end else begin
      // Frozen: phase and counters hold so the sequence resumes without loss.
      ce_cpu_q   <= 1'b0;
      ce_psg_q   <= 1'b0;
      ce_line_q  <= 1'b0;
      ce_frame_q <= 1'b0;
    end
  end

  msx_raster_counter #(
    .LINE_LEN        (LINE_LEN),
    .LINES_PER_FRAME (LINES_PER_FRAME)
  ) u_raster (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (resync),
    .en_i         (tick),
    .line_cyc_o   (line_cyc),
    .line_num_o   (line_num),
    .line_wrap_o  (line_wrap),
    .frame_wrap_o (frame_wrap)
  );

  assign ce_cpu   = ce_cpu_q;
  assign ce_psg   = ce_psg_q;
  assign ce_line  = ce_line_q;
  assign ce_frame = ce_frame_q;

endmodule

// File: tb/tb_osc_clk_enable_gen.sv
// Directed bench: default rate (A), quarter-rate INC (B) and a tiny raster (C) share the stimulus.
module tb_osc_clk_enable_gen;

  localparam int              AW    = 24;
  localparam longint unsigned INC_A = 64'd3363068;

  logic clk = 1'b0, rst = 1'b1, run = 1'b1, resync = 1'b0;

  logic       a_cpu, a_psg, a_line, a_frame;
  logic [7:0] a_cyc;
  logic [8:0] a_num;
  logic       b_cpu, b_psg, b_line, b_frame;
  logic [7:0] b_cyc;
  logic [8:0] b_num;
  logic       c_cpu, c_psg, c_line, c_frame;
  logic [7:0] c_cyc;
  logic [8:0] c_num;

  osc_clk_enable_gen u_a (
    .clk(clk), .rst(rst), .run(run), .resync(resync),
    .ce_cpu(a_cpu), .ce_psg(a_psg), .ce_line(a_line), .ce_frame(a_frame),
    .line_cyc(a_cyc), .line_num(a_num)
  );

  osc_clk_enable_gen #(.INC(32'd4194304)) u_b (
    .clk(clk), .rst(rst), .run(run), .resync(resync),
    .ce_cpu(b_cpu), .ce_psg(b_psg), .ce_line(b_line), .ce_frame(b_frame),
    .line_cyc(b_cyc), .line_num(b_num)
  );

  osc_clk_enable_gen #(.INC(32'd8388608), .LINE_LEN(4), .LINES_PER_FRAME(3)) u_c (
    .clk(clk), .rst(rst), .run(run), .resync(resync),
    .ce_cpu(c_cpu), .ce_psg(c_psg), .ce_line(c_line), .ce_frame(c_frame),
    .line_cyc(c_cyc), .line_num(c_num)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Clocks until the next overflowing add, given n adds already done.
  function automatic int next_gap(input longint unsigned n);
    longint unsigned j;
    j = 1;
    while ((((n + j) * INC_A) >> AW) == ((n * INC_A) >> AW)) j++;
    return int'(j);
  endfunction

  longint unsigned adds;
  int cnt, first, last, gapbad, posbad, psgbad, lines, bbad, cbad, kc;
  int to, gap, quiet;
  logic [7:0] cyc0;

  initial begin
    repeat (3) step();
    chk("rst_a", {a_cpu, a_psg, a_line, a_frame, a_cyc, a_num}, 0);
    chk("rst_b", {b_cpu, b_psg, b_line, b_frame, b_cyc, b_num}, 0);
    chk("rst_c", {c_cpu, c_psg, c_line, c_frame, c_cyc, c_num}, 0);

    @(negedge clk) rst = 1'b0;
    adds = 0; cnt = 0; first = 0; last = 0; gapbad = 0; posbad = 0; psgbad = 0;
    lines = 0; bbad = 0; cbad = 0;
    for (int i = 1; i <= 20000; i++) begin
      step();
      adds++;
      if (a_cpu) begin
        cnt++;
        if (first == 0) first = i;
        else if (i - last < 4 || i - last > 5) gapbad++;
        last = i;
      end
      if (a_line) lines++;
      if (a_cyc != 8'(cnt % 228) || a_num != 9'((cnt / 228) % 262)) posbad++;
      if (a_psg != (a_cpu && (cnt % 2 == 0))) psgbad++;
      if (b_cpu != (i % 4 == 0) || b_psg != (i % 8 == 0)) bbad++;
      kc = i / 2;
      if (c_cpu != (i % 2 == 0) || c_line != ((i % 2 == 0) && (kc % 4 == 0)) ||
          c_frame != ((i % 2 == 0) && (kc % 12 == 0)) ||
          c_cyc != 8'(kc % 4) || c_num != 9'((kc / 4) % 3)) cbad++;
      if (i == 8)  chk("c_line_at_4", {c_line, c_frame, c_cyc, c_num}, {1'b1, 1'b0, 8'd0, 9'd1});
      if (i == 24) chk("c_frame_at_12", {c_line, c_frame, c_cyc, c_num}, {1'b1, 1'b1, 8'd0, 9'd0});
    end
    chk("a_first_ce", first, 5);
    chk("a_gap_4_5", gapbad, 0);
    chk("a_count", cnt, (20000 * INC_A) >> AW);
    chk("a_lines", lines, cnt / 228);
    chk("a_position", posbad, 0);
    chk("a_psg_even", psgbad, 0);
    chk("b_quarter", bbad, 0);
    chk("c_raster", cbad, 0);

    // Pause mid-line for 37 clks.
    to = 0;
    while (!a_cpu && to < 10) begin step(); adds++; to++; end
    chk("pause_sync", a_cpu, 1);
    step(); adds++;
    step(); adds++;
    gap = next_gap(adds);
    cyc0 = a_cyc;
    run = 1'b0;
    quiet = 0;
    repeat (37) begin
      step();
      if ({a_cpu, a_psg, a_line, a_frame, b_cpu, b_psg, b_line, b_frame,
           c_cpu, c_psg, c_line, c_frame} != 12'd0) quiet++;
    end
    chk("pause_quiet", quiet, 0);
    chk("pause_hold", a_cyc, cyc0);
    run = 1'b1;
    to = 0;
    do begin step(); adds++; to++; end while (!a_cpu && to < 10);
    chk("resume_gap", to, gap);
    chk("resume_cyc", a_cyc, (cyc0 + 1) % 228);

    // Resync on the clk that would carry.
    to = 0;
    while (next_gap(adds) != 1 && to < 10) begin step(); adds++; to++; end
    resync = 1'b1;
    step();
    resync = 1'b0;
    adds = 0;
    chk("resync_a", {a_cpu, a_psg, a_line, a_frame, a_cyc, a_num}, 0);
    chk("resync_c", {c_cpu, c_psg, c_line, c_frame, c_cyc, c_num}, 0);
    quiet = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      adds++;
      if ({a_cpu, a_psg} != ((i == 5) ? 2'b10 : (i == 10) ? 2'b11 : 2'b00)) quiet++;
      if (i == 4) chk("resync_b_first", b_cpu, 1);
    end
    chk("resync_seq", quiet, 0);
    chk("resync_pos", {a_cyc, c_cyc, c_num}, {8'd2, 8'd2, 9'd1});

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    chk("async_rst_a", {a_cpu, a_psg, a_line, a_frame, a_cyc, a_num}, 0);
    chk("async_rst_c", {c_cpu, c_psg, c_line, c_frame, c_cyc, c_num}, 0);
    repeat (3) step();
    chk("rst_hold", {a_cpu, a_cyc, c_cpu, c_cyc, c_num}, 0);
    @(negedge clk) rst = 1'b0;
    to = 0;
    do begin step(); to++; end while (!a_cpu && to < 10);
    chk("post_rst_first", to, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
